// File: rtl/axi_mem_pkg.sv
// Shared types and helpers for the banked AXI backing memory.
// Provides width helpers, the request bundle and byte parity.
package axi_mem_pkg;

    localparam int MAX_ADDR_W = 32;
    localparam int MAX_DATA_W = 256;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int bank_bits(input int nb);
        return clog2(nb);
    endfunction

    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction

    typedef struct packed {
        logic                      we;
        logic [MAX_ADDR_W-1:0]     addr;
        logic [MAX_DATA_W-1:0]     wdata;
        logic [MAX_DATA_W/8-1:0]   wstrb;
    } mem_req_t;

    // Even parity: stored bit makes the 9-bit group have an even count of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/axi4_banked_memory_arbiter.sv
// Round-robin arbiter, one instance per bank.
// Ports: clk, rst (sync active-high), req[N] in, one-hot gnt[N] out.
module mem_rr_arbiter
    import axi_mem_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (clog2(N) == 0) ? 1 : clog2(N);

    // ptr_q is the first port searched next; it moves past the winner.
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        // First pass covers ports at/after the pointer, second wraps.
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr_q))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                ptr_d  = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                ptr_d  = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/axi4_banked_memory.sv
// Multi-port, address-interleaved banked memory with per-byte strobes.
// Ports: ACLK, ARESET (sync high), req_* per port, rsp_valid/rsp_rdata/rd_perr.
// Optional byte parity storage and checking: define AXI_MEM_PARITY_EN.
module axi4_banked_memory
    import axi_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_BANKS  = 2,
    parameter int NUM_PORTS  = 2,
    parameter int RD_LAT     = 1
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [NUM_PORTS-1:0]              req_valid,
    output logic [NUM_PORTS-1:0]              req_ready,
    input  logic [NUM_PORTS-1:0]              req_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_wstrb,
    output logic [NUM_PORTS-1:0]              rsp_valid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]   rsp_rdata,
    output logic [NUM_PORTS-1:0]              rd_perr
);

    localparam int SW    = strb_width(DATA_WIDTH);
    localparam int BB    = bank_bits(NUM_BANKS);
    localparam int BK_W  = (BB == 0) ? 1 : BB;
    localparam int ROW_W = ADDR_WIDTH - BB;
    localparam int ROWS  = 1 << ROW_W;

    if (DATA_WIDTH % 8 != 0) begin : g_err_dw
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (NUM_BANKS < 1 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_err_nb
        $error("NUM_BANKS must be a power of 2");
    end
    if (RD_LAT < 1) begin : g_err_lat
        $error("RD_LAT must be at least 1");
    end
    if (DATA_WIDTH > MAX_DATA_W || ADDR_WIDTH > MAX_ADDR_W) begin : g_err_w
        $error("width exceeds package maximum");
    end

    mem_req_t              req     [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] p_addr  [NUM_PORTS];
    logic [BK_W-1:0]       p_bank  [NUM_PORTS];
    logic [ROW_W-1:0]      p_row   [NUM_PORTS];
    logic [DATA_WIDTH-1:0] p_wdata [NUM_PORTS];
    logic [SW-1:0]         p_wstrb [NUM_PORTS];
    logic [DATA_WIDTH-1:0] rd_word [NUM_PORTS];
    logic [NUM_PORTS-1:0]  rd_fire;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            req[p].we    = req_we[p];
            req[p].addr  = MAX_ADDR_W'(req_addr[p*ADDR_WIDTH +: ADDR_WIDTH]);
            req[p].wdata = MAX_DATA_W'(req_wdata[p*DATA_WIDTH +: DATA_WIDTH]);
            req[p].wstrb = (MAX_DATA_W/8)'(req_wstrb[p*SW +: SW]);
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            p_addr[p]  = ADDR_WIDTH'(req[p].addr);
            p_wdata[p] = DATA_WIDTH'(req[p].wdata);
            p_wstrb[p] = SW'(req[p].wstrb);
            p_bank[p]  = BK_W'(p_addr[p] & ADDR_WIDTH'(NUM_BANKS - 1));
            p_row[p]   = ROW_W'(p_addr[p] >> BB);
        end
    end

    logic [NUM_PORTS-1:0]  bank_gnt [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_rd  [NUM_BANKS];
`ifdef AXI_MEM_PARITY_EN
    logic [SW-1:0]         bank_par [NUM_BANKS];
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem_q [ROWS] = '{default: '0};
`ifdef AXI_MEM_PARITY_EN
        logic [SW-1:0]         par_q [ROWS] = '{default: '0};
`endif
        logic [NUM_PORTS-1:0]  breq;
        logic [NUM_PORTS-1:0]  bgnt;
        logic [ROW_W-1:0]      g_row;
        logic                  g_we;
        logic [DATA_WIDTH-1:0] g_wdata;
        logic [SW-1:0]         g_wstrb;

        // Requests are masked in reset so nothing is granted then.
        always_comb begin
            breq = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                breq[p] = req_valid[p] & ~ARESET & (p_bank[p] == BK_W'(b));
            end
        end

        mem_rr_arbiter #(.N(NUM_PORTS)) u_arb (
            .clk (ACLK),
            .rst (ARESET),
            .req (breq),
            .gnt (bgnt)
        );

        always_comb begin
            g_row   = '0;
            g_we    = 1'b0;
            g_wdata = '0;
            g_wstrb = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bgnt[p]) begin
                    g_row   = p_row[p];
                    g_we    = req[p].we;
                    g_wdata = p_wdata[p];
                    g_wstrb = p_wstrb[p];
                end
            end
        end

        always_ff @(posedge ACLK) begin
            if (g_we) begin
                for (int i = 0; i < SW; i++) begin
                    if (g_wstrb[i]) begin
                        mem_q[g_row][8*i +: 8] <= g_wdata[8*i +: 8];
`ifdef AXI_MEM_PARITY_EN
                        par_q[g_row][i] <= byte_parity(g_wdata[8*i +: 8]);
`endif
                    end
                end
            end
        end

        assign bank_gnt[b] = bgnt;
        assign bank_rd[b]  = mem_q[g_row];
`ifdef AXI_MEM_PARITY_EN
        assign bank_par[b] = par_q[g_row];
`endif
    end

    always_comb begin
        req_ready = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            req_ready = req_ready | bank_gnt[b];
        end
    end

    // A fired port owns its bank this cycle, so the bank's row mux is its data.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_word[p] = bank_rd[p_bank[p]];
        end
    end

    assign rd_fire = req_valid & req_ready & ~req_we;

    logic [RD_LAT-1:0][NUM_PORTS-1:0]                 vld_q, vld_d;
    logic [RD_LAT-1:0][NUM_PORTS-1:0][DATA_WIDTH-1:0] dat_q, dat_d;

    // Data stages only load when valid moves in, so the last stage holds.
    always_comb begin
        vld_d    = vld_q;
        dat_d    = dat_q;
        vld_d[0] = rd_fire;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rd_fire[p]) dat_d[0][p] = rd_word[p];
        end
        for (int k = 1; k < RD_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (vld_q[k-1][p]) dat_d[k][p] = dat_q[k-1][p];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign rsp_valid = vld_q[RD_LAT-1];
    assign rsp_rdata = dat_q[RD_LAT-1];

`ifdef AXI_MEM_PARITY_EN
    logic [NUM_PORTS-1:0]              p_perr;
    logic [RD_LAT-1:0][NUM_PORTS-1:0]  perr_q, perr_d;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            p_perr[p] = 1'b0;
            for (int i = 0; i < SW; i++) begin
                if (byte_parity(rd_word[p][8*i +: 8]) != bank_par[p_bank[p]][i])
                    p_perr[p] = 1'b1;
            end
        end
    end

    always_comb begin
        perr_d    = perr_q;
        perr_d[0] = rd_fire & p_perr;
        for (int k = 1; k < RD_LAT; k++) begin
            perr_d[k] = perr_q[k-1];
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) perr_q <= '0;
        else        perr_q <= perr_d;
    end

    assign rd_perr = perr_q[RD_LAT-1];
`else
    assign rd_perr = '0;
`endif

endmodule

// File: tb/tb_axi4_banked_memory.sv
// Directed self-checking bench for axi4_banked_memory (2 ports, 2 banks).
// Runs with read latency 3; parity steps need AXI_MEM_PARITY_EN.
module tb_axi4_banked_memory;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int NP  = 2;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] valid, ready, we, rv, perr;
    logic [NP*AW-1:0]   addr;
    logic [NP*DW-1:0]   wdata, rdata;
    logic [NP*DW/8-1:0] wstrb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi4_banked_memory #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_BANKS  (2),
        .NUM_PORTS  (NP),
        .RD_LAT     (LAT)
    ) dut (
        .ACLK      (clk),
        .ARESET    (rst),
        .req_valid (valid),
        .req_ready (ready),
        .req_we    (we),
        .req_addr  (addr),
        .req_wdata (wdata),
        .req_wstrb (wstrb),
        .rsp_valid (rv),
        .rsp_rdata (rdata),
        .rd_perr   (perr)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [3:0] s);
        valid[p]          = 1'b1;
        we[p]             = w;
        addr[p*AW +: AW]  = a;
        wdata[p*DW +: DW] = d;
        wstrb[p*4 +: 4]   = s;
    endtask

    // Check grant before the edge, take the edge, then drop requests.
    task automatic issue(input string tag, input logic [NP-1:0] exp_rdy);
        @(negedge clk);
        chk(tag, 64'(ready), 64'(exp_rdy));
        @(posedge clk);
        #1;
        valid = '0;
    endtask

    task automatic wait_rsp(input string tag, input logic [NP-1:0] exp_rv,
                            input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                            input logic [NP-1:0] exp_perr);
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            chk({tag, "_rv"}, 64'(rv), (c == LAT) ? 64'(exp_rv) : 64'd0);
        end
        if (exp_rv[0]) chk({tag, "_d0"}, 64'(rdata[DW-1:0]), 64'(e0));
        if (exp_rv[1]) chk({tag, "_d1"}, 64'(rdata[2*DW-1:DW]), 64'(e1));
        chk({tag, "_perr"}, 64'(perr), 64'(exp_perr));
    endtask

    initial begin
        logic [NP-1:0] er;
        logic [NP-1:0] ev;
        int k;
        rst   = 1'b1;
        valid = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        wstrb = '0;

        // Reset state; a request during reset must not be granted.
        repeat (2) @(posedge clk);
        #1;
        set_port(0, 1'b0, 10'h005, 32'h0, 4'h0);
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_rv", 64'(rv), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_perr", 64'(perr), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Read of untouched location returns zero after exactly LAT cycles.
        issue("rd5_rdy", 2'b01);
        wait_rsp("rd5", 2'b01, 32'h0, 32'h0, 2'b00);
        @(negedge clk);
        chk("rd5_pulse", 64'(rv), 64'd0);
        @(posedge clk);
        #1;

        // Byte strobes, then a read in the very next cycle.
        set_port(0, 1'b1, 10'h010, 32'h11223344, 4'hF);
        issue("wr10a_rdy", 2'b01);
        set_port(0, 1'b1, 10'h010, 32'hAABBCCDD, 4'b0101);
        issue("wr10b_rdy", 2'b01);
        set_port(0, 1'b0, 10'h010, 32'h0, 4'h0);
        issue("rd10_rdy", 2'b01);
        wait_rsp("rd10", 2'b01, 32'h11BB33DD, 32'h0, 2'b00);
        @(negedge clk);
        chk("hold_rv", 64'(rv), 64'd0);
        chk("hold_rdata", 64'(rdata[DW-1:0]), 64'h11BB33DD);
        @(posedge clk);
        #1;

        // Different banks proceed in parallel.
        set_port(0, 1'b1, 10'h002, 32'hCAFE0002, 4'hF);
        set_port(1, 1'b1, 10'h003, 32'hBEEF0003, 4'hF);
        issue("wrpar_rdy", 2'b11);
        set_port(0, 1'b0, 10'h002, 32'h0, 4'h0);
        set_port(1, 1'b0, 10'h003, 32'h0, 4'h0);
        issue("rdpar_rdy", 2'b11);
        wait_rsp("rdpar", 2'b11, 32'hCAFE0002, 32'hBEEF0003, 2'b00);
        @(posedge clk);
        #1;

        // Reset one cycle after a read handshake drops that read.
        set_port(0, 1'b0, 10'h010, 32'h0, 4'h0);
        @(negedge clk);
        chk("mid_rdy", 64'(ready), 64'd1);
        @(posedge clk);
        #1;
        valid = '0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rdata", 64'(rdata), 64'd0);
        chk("mid_rv0", 64'(rv), 64'd0);
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            chk("mid_rv", 64'(rv), 64'd0);
        end
        @(posedge clk);
        #1;

        // Bank 0 conflict: grants alternate starting at port 0.
        set_port(0, 1'b0, 10'h010, 32'h0, 4'h0);
        set_port(1, 1'b0, 10'h002, 32'h0, 4'h0);
        for (int m = 1; m <= 4 + LAT + 1; m++) begin
            @(negedge clk);
            er = (m > 4) ? 2'b00 : ((m % 2 == 1) ? 2'b01 : 2'b10);
            k  = m - LAT;
            ev = (k < 1 || k > 4) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
            chk("rr_rdy", 64'(ready), 64'(er));
            chk("rr_rv", 64'(rv), 64'(ev));
            if (ev[0]) chk("rr_d0", 64'(rdata[DW-1:0]), 64'h11BB33DD);
            if (ev[1]) chk("rr_d1", 64'(rdata[2*DW-1:DW]), 64'hCAFE0002);
            @(posedge clk);
            #1;
            if (m == 4) valid = '0;
        end

`ifdef AXI_MEM_PARITY_EN
        set_port(0, 1'b1, 10'h020, 32'h12345678, 4'hF);
        issue("wr20_rdy", 2'b01);
        set_port(0, 1'b0, 10'h020, 32'h0, 4'h0);
        issue("rd20_rdy", 2'b01);
        wait_rsp("rd20", 2'b01, 32'h12345678, 32'h0, 2'b00);
        @(posedge clk);
        #1;
        dut.g_bank[0].mem_q[16][0] = ~dut.g_bank[0].mem_q[16][0];
        set_port(0, 1'b0, 10'h020, 32'h0, 4'h0);
        issue("rd20e_rdy", 2'b01);
        wait_rsp("rd20e", 2'b01, 32'h12345679, 32'h0, 2'b01);
        @(posedge clk);
        #1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
